// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: byte stream in, FIPS 180-4 padded 512-bit blocks out.
// Optional `SHA_PADDER_EMPTY_MSG_EN adds msg_empty_p to emit the empty-message block.
module sha_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk_p,
  input  logic         rst_p,
  input  logic [7:0]   byte_p,
  input  logic         byte_valid_p,
  input  logic         byte_last_p,
`ifdef SHA_PADDER_EMPTY_MSG_EN
  input  logic         msg_empty_p,
`endif
  output logic         byte_ready_p,
  output logic [511:0] message_p,
  output logic         message_valid_p,
  input  logic         message_ready_p,
  output logic         busy_p
);

  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [511:0]       msg_q, msg_d;
  logic [5:0]         idx_q, idx_d;
  logic [5:0]         pad_pos_q, pad_pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               final_q, final_d;
  logic               mark_done_q, mark_done_d;
  logic               extra_q, extra_d;
  logic               busy_q, busy_d;
  logic               empty_req;
  logic [63:0]        len_bits;

`ifdef SHA_PADDER_EMPTY_MSG_EN
  // A real byte in the same cycle takes priority over the empty request.
  assign empty_req = msg_empty_p && !byte_valid_p && (idx_q == 6'd0) && (cnt_q == '0);
`else
  assign empty_req = 1'b0;
`endif

  assign len_bits = 64'({cnt_q, 3'b000});

  // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    idx_d       = idx_q;
    pad_pos_d   = pad_pos_q;
    cnt_d       = cnt_q;
    final_d     = final_q;
    mark_done_d = mark_done_q;
    extra_d     = extra_q;
    busy_d      = busy_q;

    case (state_q)
      S_FILL: begin
        if (byte_valid_p) begin
          msg_d[{~idx_q, 3'b000} +: 8] = byte_p;
          idx_d  = idx_q + 6'd1;
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (byte_last_p) begin
            if (idx_q == 6'd63) begin
              // Block is full of data; marker and length go in a following block.
              state_d     = S_SEND;
              final_d     = 1'b0;
              mark_done_d = 1'b0;
              extra_d     = 1'b1;
            end else begin
              state_d   = S_PAD;
              pad_pos_d = idx_q + 6'd1;
            end
          end else if (idx_q == 6'd63) begin
            state_d = S_SEND;
            final_d = 1'b0;
            extra_d = 1'b0;
          end
        end else if (empty_req) begin
          state_d   = S_PAD;
          pad_pos_d = 6'd0;
          busy_d    = 1'b1;
        end
      end

      S_PAD: begin
        for (int k = 0; k < 64; k++) begin
          if (k == int'(pad_pos_q)) begin
            msg_d[8*(63-k) +: 8] = mark_done_q ? 8'h00 : 8'h80;
          end else if (k > int'(pad_pos_q)) begin
            msg_d[8*(63-k) +: 8] = 8'h00;
          end
        end
        mark_done_d = 1'b1;
        if (pad_pos_q <= 6'd55) begin
          msg_d[63:0] = len_bits;
          final_d     = 1'b1;
          extra_d     = 1'b0;
        end else begin
          final_d = 1'b0;
          extra_d = 1'b1;
        end
        state_d = S_SEND;
      end

      S_SEND: begin
        if (message_ready_p) begin
          if (final_q) begin
            state_d     = S_FILL;
            msg_d       = '0;
            idx_d       = 6'd0;
            cnt_d       = '0;
            final_d     = 1'b0;
            mark_done_d = 1'b0;
            busy_d      = 1'b0;
          end else if (extra_q) begin
            state_d   = S_PAD;
            pad_pos_d = 6'd0;
            extra_d   = 1'b0;
          end else begin
            state_d = S_FILL;
            idx_d   = 6'd0;
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // NOTE: the block buffer is reset too, since it drives message_p directly and must read zero after reset.
  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p) begin
      state_q     <= S_FILL;
      msg_q       <= '0;
      idx_q       <= 6'd0;
      pad_pos_q   <= 6'd0;
      cnt_q       <= '0;
      final_q     <= 1'b0;
      mark_done_q <= 1'b0;
      extra_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all registers advance together on the edge.
      state_q     <= state_d;
      msg_q       <= msg_d;
      idx_q       <= idx_d;
      pad_pos_q   <= pad_pos_d;
      cnt_q       <= cnt_d;
      final_q     <= final_d;
      mark_done_q <= mark_done_d;
      extra_q     <= extra_d;
      busy_q      <= busy_d;
    end
  end

  assign byte_ready_p    = (state_q == S_FILL);
  assign message_valid_p = (state_q == S_SEND);
  assign message_p       = msg_q;
  assign busy_p          = busy_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: a FIPS 180-4 padding model predicts every
// block, a negedge monitor compares each presented block, literals pin key cases.
module tb_sha_msg_padder;

  typedef logic [7:0] bq_t[$];

  logic         clk_p = 1'b0;
  logic         rst_p;
  logic [7:0]   byte_p;
  logic         byte_valid_p;
  logic         byte_last_p;
  logic         byte_ready_p;
  logic [511:0] message_p;
  logic         message_valid_p;
  logic         message_ready_p;
  logic         busy_p;
`ifdef SHA_PADDER_EMPTY_MSG_EN
  logic         msg_empty_p;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [511:0] exp_q[$];
  time          xfer_t;

  sha_msg_padder dut (
    .clk_p           (clk_p),
    .rst_p           (rst_p),
    .byte_p          (byte_p),
    .byte_valid_p    (byte_valid_p),
    .byte_last_p     (byte_last_p),
`ifdef SHA_PADDER_EMPTY_MSG_EN
    .msg_empty_p     (msg_empty_p),
`endif
    .byte_ready_p    (byte_ready_p),
    .message_p       (message_p),
    .message_valid_p (message_valid_p),
    .message_ready_p (message_ready_p),
    .busy_p          (busy_p)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Padding model: append 0x80, zero to 56 mod 64, then the 64-bit bit length.
  task automatic model_push(input bq_t m);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[64*b+k];
      exp_q.push_back(blk);
    end
  endtask

  // Every cycle a block is presented it must equal the oldest predicted block.
  always @(negedge clk_p) begin
    if (rst_p && message_valid_p) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", message_valid_p, 1'b0);
      end else begin
        check("block_vs_model", message_p, exp_q[0]);
        check("no_byte_ready_in_send", byte_ready_p, 1'b0);
        if (message_ready_p) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic last);
    int n = 0;
    byte_p       = b;
    byte_valid_p = 1'b1;
    byte_last_p  = last;
    @(negedge clk_p);
    while (!byte_ready_p && n < 300) begin
      n++;
      @(negedge clk_p);
    end
    if (!byte_ready_p) check("byte_ready_timeout", byte_ready_p, 1'b1);
    @(posedge clk_p);
    xfer_t = $time;
    #1;
    byte_valid_p = 1'b0;
    byte_last_p  = 1'b0;
  endtask

  task automatic send_bytes(input bq_t m);
    for (int i = 0; i < m.size(); i++) push_byte(m[i], i == m.size() - 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!message_valid_p && n < 200) begin
      @(posedge clk_p);
      #1;
      n++;
    end
    check("valid_seen", message_valid_p, 1'b1);
  endtask

  task automatic accept_block(input string name, input logic use_lit, input logic [511:0] lit);
    wait_valid();
    if (use_lit) check(name, message_p, lit);
    message_ready_p = 1'b1;
    @(posedge clk_p);
    #1;
    message_ready_p = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_p);
      #1;
      n++;
    end
    check("queue_drained", 512'(exp_q.size()), 512'd0);
  endtask

  localparam logic [511:0] ABC_BLK = {8'h61, 8'h62, 8'h63, 8'h80, 416'b0, 64'h18};

  initial begin
    bq_t m;
    time t0, t64;
    rst_p           = 1'b0;
    byte_p          = 8'h00;
    byte_valid_p    = 1'b0;
    byte_last_p     = 1'b0;
    message_ready_p = 1'b0;
`ifdef SHA_PADDER_EMPTY_MSG_EN
    msg_empty_p     = 1'b0;
`endif
    repeat (2) @(posedge clk_p);
    #1;
    check("rst_message", message_p, 512'd0);
    check("rst_valid", message_valid_p, 1'b0);
    check("rst_busy", busy_p, 1'b0);
    rst_p = 1'b1;
    @(posedge clk_p);
    #1;
    check("rst_byte_ready", byte_ready_p, 1'b1);

    // "abc" with exact PAD/SEND timing.
    m = {8'h61, 8'h62, 8'h63};
    model_push(m);
    push_byte(8'h61, 1'b0);
    check("abc_busy_high", busy_p, 1'b1);
    push_byte(8'h62, 1'b0);
    push_byte(8'h63, 1'b1);
    check("abc_pad_cycle_not_valid", message_valid_p, 1'b0);
    check("abc_pad_cycle_not_ready", byte_ready_p, 1'b0);
    @(posedge clk_p);
    #1;
    check("abc_valid_n2", message_valid_p, 1'b1);
    check("abc_block_literal", message_p, ABC_BLK);
    message_ready_p = 1'b1;
    @(posedge clk_p);
    #1;
    message_ready_p = 1'b0;
    check("abc_busy_low", busy_p, 1'b0);
    check("abc_back_to_fill", byte_ready_p, 1'b1);
    check("abc_buffer_cleared", message_p, 512'd0);

    // 55 zero bytes: marker and length fit in one block.
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    model_push(m);
    send_bytes(m);
    accept_block("len55_literal", 1'b1, {440'b0, 8'h80, 64'h1B8});

    // 56 bytes: length spills into a second block.
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'hA5 ^ 8'(i));
    model_push(m);
    send_bytes(m);
    accept_block("len56_first", 1'b0, '0);
    accept_block("len56_second_literal", 1'b1, {448'b0, 64'h1C0});

    // 64 bytes 0x00..0x3F: data block immediately, marker opens the next one.
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i));
    model_push(m);
    send_bytes(m);
    check("len64_valid_n1", message_valid_p, 1'b1);
    accept_block("len64_first", 1'b0, '0);
    accept_block("len64_second_literal", 1'b1, {8'h80, 440'b0, 64'h200});

    // Back-pressure: ten stalled cycles in SEND, accept on the eleventh.
    m = {8'h01, 8'h02, 8'h03};
    model_push(m);
    send_bytes(m);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid_held", message_valid_p, 1'b1);
      check("stall_no_byte_ready", byte_ready_p, 1'b0);
      @(posedge clk_p);
      #1;
    end
    message_ready_p = 1'b1;
    @(posedge clk_p);
    #1;
    message_ready_p = 1'b0;
    check("stall_resume_fill", byte_ready_p, 1'b1);

    // 70 bytes with the core always ready: continuation block costs 65 cycles.
    m = {};
    for (int i = 0; i < 70; i++) m.push_back(8'(3 * i + 7));
    model_push(m);
    message_ready_p = 1'b1;
    t0  = 0;
    t64 = 0;
    for (int i = 0; i < 70; i++) begin
      push_byte(m[i], i == 69);
      if (i == 0)  t0  = xfer_t;
      if (i == 64) t64 = xfer_t;
    end
    wait_drained();
    message_ready_p = 1'b0;
    check("cont_block_cycles", 512'((t64 - t0) / 10), 512'd65);
    check("cont_busy_low", busy_p, 1'b0);

    // Reset in the middle of a message discards it.
    for (int i = 0; i < 20; i++) push_byte(8'(i + 1), 1'b0);
    #2;
    rst_p = 1'b0;
    #1;
    check("midrst_message", message_p, 512'd0);
    check("midrst_valid", message_valid_p, 1'b0);
    check("midrst_busy", busy_p, 1'b0);
    check("midrst_byte_ready", byte_ready_p, 1'b1);
    @(posedge clk_p);
    #1;
    rst_p = 1'b1;
    m = {8'h61, 8'h62, 8'h63};
    model_push(m);
    send_bytes(m);
    accept_block("midrst_abc_literal", 1'b1, ABC_BLK);

`ifdef SHA_PADDER_EMPTY_MSG_EN
    m = {};
    model_push(m);
    msg_empty_p = 1'b1;
    @(posedge clk_p);
    #1;
    msg_empty_p = 1'b0;
    accept_block("empty_literal", 1'b1, {8'h80, 504'b0});
    check("empty_busy_low", busy_p, 1'b0);
`endif

    repeat (2) @(posedge clk_p);
    #1;
    check("queue_empty_at_end", 512'(exp_q.size()), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
